// File: rtl/qtree_pkg.sv
// rtl/qtree_pkg.sv - shared types and helpers for the quadtree leaf stage
package qtree_pkg;

   localparam int unsigned LEAF_ADDR_W  = 4;
   localparam int unsigned LEAF_KEY_W   = 16;
   localparam int unsigned LEAF_VALUE_W = 16;
   localparam int unsigned LEAF_BYP_W   = 1;

   // Leaf RAM word, MSB to LSB: {valid, key, value}
   typedef struct packed {
      logic                    valid;
      logic [LEAF_KEY_W-1:0]   key;
      logic [LEAF_VALUE_W-1:0] value;
   } leaf_ram_data_t;

   // Per-stage payload travelling alongside the RAM read
   typedef struct packed {
      logic [LEAF_KEY_W-1:0]   lookup_value;
      logic [LEAF_BYP_W-1:0]   bypass;
      logic                    hit;
      logic [LEAF_VALUE_W-1:0] value;
   } stage_pipe_t;

   // Exact match: the entry must be populated and its key identical
   function automatic logic leaf_match(input leaf_ram_data_t entry,
                                       input logic [LEAF_KEY_W-1:0] lookup);
      return entry.valid && (entry.key == lookup);
   endfunction

endpackage

// File: rtl/qtree_sync_fifo.sv
// rtl/qtree_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module qtree_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointer and count update; callers never push when full without a pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/qtree_leaf.sv
// rtl/qtree_leaf.sv - leaf RAM read, exact-match compare and result queue
module qtree_leaf
   import qtree_pkg::*;
#(
   parameter int ADDR_WIDTH   = LEAF_ADDR_W,
   parameter int KEY_WIDTH    = LEAF_KEY_W,
   parameter int VALUE_WIDTH  = LEAF_VALUE_W,
   parameter int BYPASS_WIDTH = LEAF_BYP_W,
   parameter int FIFO_DEPTH   = 8,
   parameter int AF_MARGIN    = 3
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [ADDR_WIDTH-1:0]              mm_ram_addr_i,
   input  logic [KEY_WIDTH+VALUE_WIDTH:0]     mm_ram_data_i,
   input  logic                               mm_ram_write_i,
   input  logic [KEY_WIDTH-1:0]               in_lookup_value_i,
   input  logic [ADDR_WIDTH-1:0]              in_addr_i,
   input  logic [BYPASS_WIDTH-1:0]            in_bypass_i,
   input  logic                               in_valid_i,
   output logic                               out_hit_o,
   output logic [VALUE_WIDTH-1:0]             out_value_o,
   output logic [BYPASS_WIDTH-1:0]            out_bypass_o,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]        fill_level_o,
   output logic                               almost_full_o,
   output logic                               overflow_o
);

   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int FIFO_W    = 1 + VALUE_WIDTH + BYPASS_WIDTH;
   localparam int AF_LEVEL  = FIFO_DEPTH - AF_MARGIN;

   leaf_ram_data_t ram_q [RAM_DEPTH];
   leaf_ram_data_t rd_data_q, rd_data_d;

   logic        s1_valid_q, s1_valid_d;
   stage_pipe_t s1_q, s1_d;
   logic        s2_valid_q, s2_valid_d;
   stage_pipe_t s2_q, s2_d;
   logic        overflow_q, overflow_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic [FIFO_W-1:0] fifo_wdata;
   logic [FIFO_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W:0]    af_sum;
   logic              unused_stage_bits;

   // Leaf RAM write port; not reset, software initialises every entry
   always_ff @(posedge clk_i) begin
      if (mm_ram_write_i) begin
         ram_q[mm_ram_addr_i] <= mm_ram_data_i;
      end
   end

   // Read port sees the array before this edge's write, so a same-address
   // collision returns the old word
   always_comb begin
      rd_data_d = rd_data_q;
      if (in_valid_i) begin
         rd_data_d = ram_q[in_addr_i];
      end
   end

   // Registered read data, aligned with stage 1
   always_ff @(posedge clk_i) begin
      rd_data_q <= rd_data_d;
   end

   // Stage 1 captures the request, stage 2 captures the compare result
   always_comb begin
      s1_valid_d = in_valid_i;
      s1_d       = s1_q;
      if (in_valid_i) begin
         s1_d.lookup_value = in_lookup_value_i;
         s1_d.bypass       = in_bypass_i;
         s1_d.hit          = 1'b0;
         s1_d.value        = '0;
      end

      s2_valid_d = s1_valid_q;
      s2_d       = s2_q;
      if (s1_valid_q) begin
         s2_d.lookup_value = s1_q.lookup_value;
         s2_d.bypass       = s1_q.bypass;
         s2_d.hit          = leaf_match(rd_data_q, s1_q.lookup_value);
         s2_d.value        = s2_d.hit ? rd_data_q.value : '0;
      end
   end

   // Pipeline registers; in-flight requests are discarded on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         s2_q       <= s2_d;
      end
   end

   // A full FIFO still takes a result when a pop frees the slot this cycle;
   // otherwise the result is dropped and the loss is remembered
   always_comb begin
      fifo_pop   = ~fifo_empty & out_ready_i;
      fifo_push  = s2_valid_q & (~fifo_full | fifo_pop);
      fifo_wdata = {s2_q.hit, s2_q.value, s2_q.bypass};
      overflow_d = overflow_q | (s2_valid_q & fifo_full & ~fifo_pop);
   end

   // Sticky drop flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   qtree_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (fifo_wdata),
      .data_o  (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Occupancy plus results still in the pipe, so upstream stops early
   // enough that nothing already issued can be lost
   always_comb begin
      af_sum = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_q) + (CNT_W + 1)'(s2_valid_q);
   end

   assign almost_full_o = (af_sum >= (CNT_W + 1)'(AF_LEVEL));
   assign fill_level_o  = fifo_count;
   assign overflow_o    = overflow_q;
   assign out_valid_o   = ~fifo_empty;

   // Head fields are forced to zero while empty so reset shows clean outputs
   assign out_hit_o    = out_valid_o & fifo_rdata[FIFO_W-1];
   assign out_value_o  = out_valid_o ? fifo_rdata[FIFO_W-2:BYPASS_WIDTH] : '0;
   assign out_bypass_o = out_valid_o ? fifo_rdata[BYPASS_WIDTH-1:0] : '0;

   // Struct fields carried for uniformity but not consumed at their stage
   assign unused_stage_bits = ^{s1_q.hit, s1_q.value, s2_q.lookup_value};

endmodule

// File: tb/tb_qtree_leaf.sv
// tb/tb_qtree_leaf.sv - directed self-checking bench for qtree_leaf
module tb_qtree_leaf;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [3:0]  mm_ram_addr_i = '0;
   logic [32:0] mm_ram_data_i = '0;
   logic        mm_ram_write_i = 1'b0;
   logic [15:0] in_lookup_value_i = '0;
   logic [3:0]  in_addr_i = '0;
   logic [0:0]  in_bypass_i = '0;
   logic        in_valid_i = 1'b0;
   logic        out_hit_o;
   logic [15:0] out_value_o;
   logic [0:0]  out_bypass_o;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [3:0]  fill_level_o;
   logic        almost_full_o;
   logic        overflow_o;

   int n_cmp  = 0;
   int n_fail = 0;

   qtree_leaf #(
      .ADDR_WIDTH   (4),
      .KEY_WIDTH    (16),
      .VALUE_WIDTH  (16),
      .BYPASS_WIDTH (1),
      .FIFO_DEPTH   (8),
      .AF_MARGIN    (3)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .mm_ram_addr_i     (mm_ram_addr_i),
      .mm_ram_data_i     (mm_ram_data_i),
      .mm_ram_write_i    (mm_ram_write_i),
      .in_lookup_value_i (in_lookup_value_i),
      .in_addr_i         (in_addr_i),
      .in_bypass_i       (in_bypass_i),
      .in_valid_i        (in_valid_i),
      .out_hit_o         (out_hit_o),
      .out_value_o       (out_value_o),
      .out_bypass_o      (out_bypass_o),
      .out_valid_o       (out_valid_o),
      .out_ready_i       (out_ready_i),
      .fill_level_o      (fill_level_o),
      .almost_full_o     (almost_full_o),
      .overflow_o        (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid_i = 1'b0;
      repeat (n) tick();
   endtask

   task automatic write_ram(input logic [3:0] a, input logic v, input logic [15:0] k,
                            input logic [15:0] val);
      mm_ram_addr_i  = a;
      mm_ram_data_i  = {v, k, val};
      mm_ram_write_i = 1'b1;
      tick();
      mm_ram_write_i = 1'b0;
   endtask

   task automatic issue(input logic [3:0] a, input logic [15:0] k, input logic b);
      in_addr_i         = a;
      in_lookup_value_i = k;
      in_bypass_i       = b;
      in_valid_i        = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", out_valid_o); end
      n_cmp++; if (fill_level_o !== 4'd0) begin n_fail++; $display("FAIL rst_fill: got %0d expected 0", fill_level_o); end
      n_cmp++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL rst_af: got %b expected 0", almost_full_o); end
      n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", overflow_o); end
      n_cmp++; if ({out_hit_o, out_value_o, out_bypass_o} !== 18'd0) begin n_fail++; $display("FAIL rst_head: got %h expected 0", {out_hit_o, out_value_o, out_bypass_o}); end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_single_hit();
      write_ram(4'd3, 1'b1, 16'h1234, 16'hBEEF);
      tick();
      out_ready_i = 1'b1;
      issue(4'd3, 16'h1234, 1'b1);
      in_valid_i = 1'b0;
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL hit_lat0: got %b expected 0", out_valid_o); end
      tick();
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL hit_lat1: got %b expected 0", out_valid_o); end
      tick();
      n_cmp++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL hit_valid: got %b expected 1", out_valid_o); end
      n_cmp++; if (out_hit_o !== 1'b1) begin n_fail++; $display("FAIL hit_hit: got %b expected 1", out_hit_o); end
      n_cmp++; if (out_value_o !== 16'hBEEF) begin n_fail++; $display("FAIL hit_value: got %h expected beef", out_value_o); end
      n_cmp++; if (out_bypass_o !== 1'b1) begin n_fail++; $display("FAIL hit_bypass: got %b expected 1", out_bypass_o); end
      n_cmp++; if (fill_level_o !== 4'd1) begin n_fail++; $display("FAIL hit_fill: got %0d expected 1", fill_level_o); end
      tick();
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL hit_popped: got %b expected 0", out_valid_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_miss();
      write_ram(4'd5, 1'b0, 16'h1234, 16'hAAAA);
      write_ram(4'd6, 1'b1, 16'h1234, 16'hCCCC);
      out_ready_i = 1'b1;
      issue(4'd5, 16'h1234, 1'b0);
      issue(4'd6, 16'h1235, 1'b1);
      in_valid_i = 1'b0;
      tick();
      n_cmp++; if ({out_valid_o, out_hit_o, out_value_o, out_bypass_o} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL miss_invalid: got v%b h%b %h b%b expected v1 h0 0000 b0", out_valid_o, out_hit_o, out_value_o, out_bypass_o); end
      tick();
      n_cmp++; if ({out_valid_o, out_hit_o, out_value_o, out_bypass_o} !== {1'b1, 1'b0, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL miss_key: got v%b h%b %h b%b expected v1 h0 0000 b1", out_valid_o, out_hit_o, out_value_o, out_bypass_o); end
      tick();
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL miss_empty: got %b expected 0", out_valid_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_val;
      logic        exp_hit;
      logic [3:0]  exp_fill;
      for (int a = 0; a < 8; a++) begin
         write_ram(4'(8 + a), 1'b1, 16'(16'h0100 + a), 16'(16'h1000 + a));
      end
      out_ready_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) issue(4'(8 + k), (k == 5) ? 16'h0F00 : 16'(16'h0100 + k), k[0]);
         else idle(1);
         exp_fill = (k == 0) ? 4'd0 : 4'(k - 1);
         n_cmp++; if (almost_full_o !== (k >= 4)) begin n_fail++; $display("FAIL b2b_af[%0d]: got %b expected %b", k, almost_full_o, (k >= 4)); end
         n_cmp++; if (fill_level_o !== exp_fill) begin n_fail++; $display("FAIL b2b_fill[%0d]: got %0d expected %0d", k, fill_level_o, exp_fill); end
      end
      n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", overflow_o); end
      out_ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         exp_hit = (j != 5);
         exp_val = exp_hit ? 16'(16'h1000 + j) : 16'h0000;
         n_cmp++; if ({out_valid_o, out_hit_o, out_value_o, out_bypass_o} !== {1'b1, exp_hit, exp_val, j[0]}) begin n_fail++; $display("FAIL b2b_drain[%0d]: got v%b h%b %h b%b expected v1 h%b %h b%b", j, out_valid_o, out_hit_o, out_value_o, out_bypass_o, exp_hit, exp_val, j[0]); end
         tick();
      end
      n_cmp++; if ({out_valid_o, fill_level_o, almost_full_o} !== 6'd0) begin n_fail++; $display("FAIL b2b_empty: got v%b f%0d af%b expected v0 f0 af0", out_valid_o, fill_level_o, almost_full_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_full_pop();
      logic [15:0] exp_val;
      out_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) issue(4'(8 + i), 16'(16'h0100 + i), i[0]);
      idle(2);
      n_cmp++; if (fill_level_o !== 4'd8) begin n_fail++; $display("FAIL fp_full: got %0d expected 8", fill_level_o); end
      issue(4'd10, 16'h0102, 1'b1);
      in_valid_i = 1'b0;
      tick();
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      n_cmp++; if (fill_level_o !== 4'd8) begin n_fail++; $display("FAIL fp_count: got %0d expected 8", fill_level_o); end
      n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %b expected 0", overflow_o); end
      out_ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         exp_val = (j < 7) ? 16'(16'h1001 + j) : 16'h1002;
         n_cmp++; if ({out_valid_o, out_value_o} !== {1'b1, exp_val}) begin n_fail++; $display("FAIL fp_drain[%0d]: got v%b %h expected v1 %h", j, out_valid_o, out_value_o, exp_val); end
         tick();
      end
      n_cmp++; if (fill_level_o !== 4'd0) begin n_fail++; $display("FAIL fp_empty: got %0d expected 0", fill_level_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_overflow();
      logic [15:0] exp_val;
      out_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) issue(4'(8 + (i % 8)), 16'(16'h0100 + (i % 8)), i[0]);
      idle(3);
      n_cmp++; if (fill_level_o !== 4'd8) begin n_fail++; $display("FAIL ovf_fill: got %0d expected 8", fill_level_o); end
      n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
      n_cmp++; if (almost_full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_af: got %b expected 1", almost_full_o); end
      out_ready_i = 1'b1;
      for (int j = 0; j < 8; j++) begin
         exp_val = 16'(16'h1000 + j);
         n_cmp++; if ({out_valid_o, out_hit_o, out_value_o} !== {1'b1, 1'b1, exp_val}) begin n_fail++; $display("FAIL ovf_drain[%0d]: got v%b h%b %h expected v1 h1 %h", j, out_valid_o, out_hit_o, out_value_o, exp_val); end
         tick();
      end
      n_cmp++; if ({out_valid_o, fill_level_o} !== 5'd0) begin n_fail++; $display("FAIL ovf_empty: got v%b f%0d expected v0 f0", out_valid_o, fill_level_o); end
      n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
      out_ready_i = 1'b0;
   endtask

   task automatic test_mid_reset();
      out_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) issue(4'(8 + i), 16'(16'h0100 + i), i[0]);
      in_valid_i = 1'b0;
      n_cmp++; if (fill_level_o !== 4'd4) begin n_fail++; $display("FAIL mr_pre_fill: got %0d expected 4", fill_level_o); end
      n_cmp++; if (almost_full_o !== 1'b1) begin n_fail++; $display("FAIL mr_pre_af: got %b expected 1", almost_full_o); end
      #3;
      rst_i = 1'b1;
      #1;
      n_cmp++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b expected 0", out_valid_o); end
      n_cmp++; if (fill_level_o !== 4'd0) begin n_fail++; $display("FAIL mr_fill: got %0d expected 0", fill_level_o); end
      n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL mr_ovf: got %b expected 0", overflow_o); end
      n_cmp++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL mr_af: got %b expected 0", almost_full_o); end
      tick();
      tick();
      rst_i = 1'b0;
      idle(4);
      n_cmp++; if ({out_valid_o, fill_level_o} !== 5'd0) begin n_fail++; $display("FAIL mr_after: got v%b f%0d expected v0 f0", out_valid_o, fill_level_o); end
      out_ready_i = 1'b1;
      issue(4'd3, 16'h1234, 1'b1);
      in_valid_i = 1'b0;
      tick();
      tick();
      n_cmp++; if ({out_valid_o, out_hit_o, out_value_o, out_bypass_o} !== {1'b1, 1'b1, 16'hBEEF, 1'b1}) begin n_fail++; $display("FAIL mr_ram_kept: got v%b h%b %h b%b expected v1 h1 beef b1", out_valid_o, out_hit_o, out_value_o, out_bypass_o); end
      tick();
      out_ready_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_miss();
      test_back_to_back();
      test_full_pop();
      test_overflow();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/qtree_leaf.md
# qtree_leaf

Final stage of the quadtree lookup pipeline: consumes the leaf address and lookup value emitted by the last tree level, reads the leaf RAM at that address, performs an exact-match compare, and queues the result in an output FIFO with a valid/ready interface. The tree levels have no backpressure, so the block also reports an occupancy-based almost-full indication for upstream admission control and flags any dropped result.

## Interface
- ADDR_WIDTH, 4: leaf RAM address width; the leaf RAM holds 2^ADDR_WIDTH entries.
- KEY_WIDTH, 16: lookup value / stored key width.
- VALUE_WIDTH, 16: stored result value width.
- BYPASS_WIDTH, 1: opaque per-request tag, carried unchanged.
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥ 4.
- AF_MARGIN, 3: almost-full threshold margin; must satisfy 2 ≤ AF_MARGIN < FIFO_DEPTH.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- mm_ram_addr_i  in  ADDR_WIDTH  leaf RAM write address.
- mm_ram_data_i  in  1+KEY_WIDTH+VALUE_WIDTH  leaf entry {valid, key, value}.
- mm_ram_write_i  in  1  leaf RAM write strobe.
- in_lookup_value_i  in  KEY_WIDTH  lookup value from the last level.
- in_addr_i  in  ADDR_WIDTH  leaf address from the last level.
- in_bypass_i  in  BYPASS_WIDTH  request tag.
- in_valid_i  in  1  request valid. There is no ready signal; requests are always accepted.
- out_hit_o  out  1  exact match found.
- out_value_o  out  VALUE_WIDTH  matched value; 0 on a miss.
- out_bypass_o  out  BYPASS_WIDTH  request tag.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer ready.
- fill_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- almost_full_o  out  1  upstream must stop injecting.
- overflow_o  out  1  sticky; at least one result was dropped.

## Operation
- Stage 1:
  - On in_valid_i, present in_addr_i to the leaf RAM.
  - Register lookup value, bypass and valid alongside the read.
- Stage 2: compare, then register the result.
  - hit = entry.valid & (entry.key == lookup_value).
  - value = hit ? entry.value : 0.
- Stage 3: on stage-2 valid, push {hit, value, bypass} into the FIFO.
- FIFO:
  - Show-ahead: the head is presented on out_* while out_valid_o = (count ≠ 0).
  - A pop occurs on out_valid_o & out_ready_i.
- Leaf RAM:
  - Simple dual-port, one write and one read per cycle.
  - A read and write to the same address in the same cycle returns the old data.
  - Contents are not reset; software writes every entry before use.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the result is dropped, count is unchanged, and overflow_o is set.
- overflow_o clears only on rst_i.
- inflight = number of valid stage-1 and stage-2 registers (0–2).
- almost_full_o = (count + inflight) ≥ FIFO_DEPTH − AF_MARGIN. It is combinational from registers, with no dependence on in_valid_i.
- fill_level_o = count. Pointers wrap modulo FIFO_DEPTH; count saturates at neither end, so correctness comes from the push/pop rules above.

## Timing
- Request sampled at edge 0 → FIFO write at edge 2 → out_valid_o high after edge 2 if the FIFO was empty.
  - Latency is 2 cycles, fixed and independent of occupancy.
- Throughput: one request per cycle. Results leave in request order.
- Simultaneous push and pop when empty: both occur, with no combinational bypass. The pushed entry appears the next cycle.
- Reset (asynchronous, any time):
  - Stage valids, FIFO pointers and count are cleared; all in-flight requests are lost.
  - Outputs: out_valid_o=0, fill_level_o=0, almost_full_o=0, overflow_o=0.
  - out_hit_o, out_value_o and out_bypass_o are 0.
- A RAM write at edge k is visible to requests sampled at edge k+1 or later.

## Structure
- The shared package qtree_pkg holds:
  - leaf_ram_data_t {valid, key, value}, ordered MSB to LSB;
  - the stage pipe struct {lookup_value, bypass, hit, value}.
- Sub-module qtree_sync_fifo:
  - parameters WIDTH and DEPTH;
  - ports push, pop, data in/out, count, full, empty;
  - no overflow logic inside; the parent owns drop and overflow handling.
- Leaf RAM is inferred inline as a registered-read array.

## Test plan
- Single hit:
  - Stimulus: write addr 3 = {1, 0x1234, 0xBEEF}; after 1 idle cycle, request lookup 0x1234, addr 3, bypass 1, with out_ready_i=1.
  - Response: out_valid_o asserts 2 cycles after the request with hit=1, value=0xBEEF, bypass=1.
- Miss cases:
  - Entry valid=0 with matching key → hit=0, value=0.
  - valid=1 with key 0x1235 → hit=0, value=0.
- Back-to-back and backpressure:
  - Stimulus: 8 consecutive requests to alternating addresses with out_ready_i=0.
  - Response: fill_level_o climbs to 8; almost_full_o is high once count+inflight ≥ 5; no overflow.
  - Then raise out_ready_i: 8 results drain in order, one per cycle.
- Overflow:
  - Stimulus: 10 requests with out_ready_i=0 and FIFO_DEPTH=8.
  - Response: the first 8 are retained, the last 2 are dropped, overflow_o=1 and stays 1 after draining.
- Full with simultaneous pop: with the FIFO at 8, push and pop in the same cycle → count stays 8, no overflow.
- Mid-operation reset:
  - Stimulus: assert rst_i asynchronously with 4 queued results and 2 in flight.
  - Response: out_valid_o=0, fill_level_o=0 and overflow_o=0 immediately; nothing appears after release.
  - Leaf RAM contents are retained.
